// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: control codes, slice
// operation selects and sequencer FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_ADD  = 2'b10,
        OP_LESS = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        SLT_FIX = 2'b10,
        DONE    = 2'b11
    } state_e;

    typedef struct packed {
        logic    a_invert;
        logic    b_invert;
        alu_op_e operation;
    } alu_dec_t;

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/result bundle between the operand registers, the serial ALU
// sequencer and writeback.
interface alu_serial_ctrl_if #(parameter int WIDTH = 32);

    logic             start_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       ctrl_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             cout_o;
    logic             overflow_o;

    modport master (
        output start_i, src1_i, src2_i, ctrl_i,
        input  busy_o, done_o, result_o, zero_o, cout_o, overflow_o
    );

    modport slave (
        input  start_i, src1_i, src2_i, ctrl_i,
        output busy_o, done_o, result_o, zero_o, cout_o, overflow_o
    );

endinterface

// File: rtl/alu_top.sv
// One-bit ALU slice: optional input inversion, then AND / OR / full-add sum /
// pass-through of the less input.
module alu_top
    import alu_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    a_invert,
    input  logic    b_invert,
    input  logic    cin,
    input  logic    less,
    input  alu_op_e operation,
    output logic    result,
    output logic    cout
);

    logic a_eff;
    logic b_eff;

    always_comb begin
        a_eff = a ^ a_invert;
        b_eff = b ^ b_invert;
        cout  = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);
        case (operation)
            OP_AND:  result = a_eff & b_eff;
            OP_OR:   result = a_eff | b_eff;
            OP_ADD:  result = a_eff ^ b_eff ^ cin;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: walks one alu_top slice over the latched operands
// LSB first, rippling the carry through a flop, and publishes result/flags.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    alu_serial_ctrl_if.slave   bus
);

    localparam int              IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    alu_dec_t         dec_q;
    logic             is_slt_q;
    logic [WIDTH-1:0] sr_q;
    logic             cin_msb_q;
    logic             cout_msb_q;
    logic             slice_res;
    logic             slice_cout;
    logic             accept;
    logic             arith;

    function automatic alu_dec_t decode(input logic [3:0] code);
        case (code)
            ALU_OR:   decode = '{1'b0, 1'b0, OP_OR};
            ALU_ADD:  decode = '{1'b0, 1'b0, OP_ADD};
            ALU_SUB:  decode = '{1'b0, 1'b1, OP_ADD};
            ALU_SLT:  decode = '{1'b0, 1'b1, OP_ADD};
            ALU_NOR:  decode = '{1'b1, 1'b1, OP_AND};
            ALU_NAND: decode = '{1'b1, 1'b1, OP_OR};
            default:  decode = '{1'b0, 1'b0, OP_AND};
        endcase
    endfunction

    alu_top u_slice (
        .a         (a_q[idx_q]),
        .b         (b_q[idx_q]),
        .a_invert  (dec_q.a_invert),
        .b_invert  (dec_q.b_invert),
        .cin       (carry_q),
        .less      (1'b0),
        .operation (dec_q.operation),
        .result    (slice_res),
        .cout      (slice_cout)
    );

    // The done_o cycle is spent in IDLE, so a start there must still be refused.
    assign accept = (state_q == IDLE) && bus.start_i && !bus.done_o;
    assign arith  = (dec_q.operation == OP_ADD);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = is_slt_q ? SLT_FIX : DONE;
            SLT_FIX: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q          <= '0;
            carry_q        <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            dec_q          <= '{1'b0, 1'b0, OP_AND};
            is_slt_q       <= 1'b0;
            sr_q           <= '0;
            cin_msb_q      <= 1'b0;
            cout_msb_q     <= 1'b0;
            bus.busy_o     <= 1'b0;
            bus.done_o     <= 1'b0;
            bus.result_o   <= '0;
            bus.zero_o     <= 1'b1;
            bus.cout_o     <= 1'b0;
            bus.overflow_o <= 1'b0;
        end else begin
            bus.done_o <= 1'b0;
            if (bus.done_o) bus.busy_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q        <= bus.src1_i;
                        b_q        <= bus.src2_i;
                        dec_q      <= decode(bus.ctrl_i);
                        is_slt_q   <= (bus.ctrl_i == ALU_SLT);
                        carry_q    <= (bus.ctrl_i == ALU_SUB) || (bus.ctrl_i == ALU_SLT);
                        idx_q      <= '0;
                        bus.busy_o <= 1'b1;
                    end
                end
                RUN: begin
                    sr_q    <= {slice_res, sr_q[WIDTH-1:1]};
                    carry_q <= slice_cout;
                    if (idx_q == LAST_IDX) begin
                        idx_q      <= '0;
                        cin_msb_q  <= carry_q;
                        cout_msb_q <= slice_cout;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                SLT_FIX: begin
                    // Signed less-than: sign of a-b corrected by overflow.
                    sr_q <= {{(WIDTH-1){1'b0}}, sr_q[WIDTH-1] ^ (cin_msb_q ^ cout_msb_q)};
                end
                DONE: begin
                    bus.result_o   <= sr_q;
                    bus.zero_o     <= (sr_q == '0);
                    bus.cout_o     <= arith ? cout_msb_q : 1'b0;
                    bus.overflow_o <= arith ? (cin_msb_q ^ cout_msb_q) : 1'b0;
                    bus.done_o     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
